lap_recall: RTL and testbench
=============================

Name: lap_recall

Overview:
- Sits between the BCD time counters and the display interface.
- Conditions a raw lap pushbutton and a raw recall pushbutton.
- Stores up to DEPTH lap times, which are snapshots of the 16-bit BCD time value.
- Selects what the display shows: live time, a held lap value for a fixed time, or stored laps stepped through newest-to-oldest.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable clk5 cycles needed to accept a new button level (10 ms at 5 MHz).
- HOLD_CYCLES, 15000000: clk5 cycles a freshly captured lap stays on the display (3 s).
- DEPTH, 4: number of lap entries; must be a power of 2, minimum 2.

Ports:
- clk5  input  1: 5 MHz system clock; all logic on its rising edge.
- reset  input  1: synchronous, active-high reset.
- lapPB  input  1: raw lap pushbutton, asynchronous, active-high.
- recallPB  input  1: raw recall pushbutton, asynchronous, active-high.
- run  input  1: stopwatch running flag from the control state machine.
- timevalue  input  16: live BCD time {value4, value3, value2, value1}.
- dispValue  output  16: BCD value sent to the display interface; registered.
- lapCount  output  log2(DEPTH)+1: number of valid stored laps, 0..DEPTH.
- holding  output  1: high while in the HOLD state.
- recalling  output  1: high while in the RECALL state.

Behaviour:
- Reset, effective on the clock edge with reset=1:
  - State = LIVE.
  - dispValue = 0, lapCount = 0, holding = 0, recalling = 0.
  - Write pointer = 0, read index = 0, hold timer = 0.
  - All lap entries = 0.
  - Sync flops and debounced levels = 0.
- Reset asserted mid-HOLD or mid-RECALL behaves identically to a reset from LIVE.
- Button conditioning, applied to each button independently:
  - 2-flop synchronizer.
  - Debounce counter counts while the synced level differs from the debounced level; it clears whenever the two are equal.
  - When the count reaches DEBOUNCE_CYCLES-1 on a cycle where the levels still differ, the debounced level takes the synced value and the counter clears.
  - A 0->1 transition of the debounced level produces a one-cycle pulse: lapP or recallP.
  - Releasing the button produces no pulse.
  - Holding the button produces exactly one pulse.
- Lap capture:
  - Occurs on lapP when run=1 and state is LIVE or HOLD.
  - timevalue is written to lap[wrPtr]; wrPtr increments modulo DEPTH.
  - lapCount increments, saturating at DEPTH.
  - Once DEPTH laps are stored, each new capture overwrites the oldest entry.
  - lapP with run=0 is ignored; there is no capture and no state change.
- State LIVE:
  - dispValue <= timevalue each cycle (1-cycle latency).
  - On a capture: go to HOLD, load the hold timer with HOLD_CYCLES-1, and set dispValue <= timevalue being captured.
  - Otherwise, on recallP with lapCount>0: go to RECALL with read index = newest entry (wrPtr-1), and set dispValue <= that entry.
  - recallP with lapCount=0 is ignored.
- State HOLD:
  - dispValue is frozen.
  - The timer decrements each cycle; when it reaches 0, go to LIVE on the next edge.
  - A new capture in HOLD reloads the timer and shows the new lap.
  - recallP in HOLD goes to RECALL, as from LIVE.
- State RECALL:
  - dispValue = lap[read index]; run and timevalue are not shown, but counting continues upstream.
  - Each recallP steps read index to the next-older entry (decrement modulo DEPTH).
  - Once lapCount entries have been shown, the next recallP returns to LIVE.
  - lapP in RECALL is ignored: no capture.
- Simultaneous lapP and recallP in the same cycle: lapP takes priority and recallP is dropped.
- holding and recalling are registered decodes of the state and update on the same edge as the state.

Test Plan:
1. DEBOUNCE_CYCLES=4; assert lapPB with run=1 and timevalue=16'h0123; apply 2-cycle glitches first. -> Glitches produce no pulse. A stable press captures 0123, lapCount=1, holding=1 and dispValue=0123 while timevalue advances.
2. HOLD_CYCLES=10; capture a lap, then let the hold expire. -> dispValue=0123 for exactly 10 cycles, then tracks timevalue with 1-cycle latency; holding=0.
3. DEPTH=4; capture 5 laps at 0001..0005, then press recall 5 times. -> dispValue sequence 0005, 0004, 0003, 0002, then LIVE; lapCount=4.
4. run=0; press lap. -> No capture, lapCount unchanged, state stays LIVE. Recall pressed with lapCount=0 -> stays LIVE.
5. lapPB and recallPB debounced on the same cycle in LIVE. -> Lap is captured and the block enters HOLD; no RECALL.
6. Assert reset mid-RECALL. -> Next cycle: dispValue=0, lapCount=0, recalling=0. A subsequent recall press is ignored.

Source files
------------

// File: rtl/lap_recall.sv
// Lap capture and recall between the BCD time counters and the display:
// conditions the lap/recall buttons, stores DEPTH lap snapshots and picks the display source.

module lap_recall_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk5,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: every clocked block uses non-blocking assignments so all flops sample
  // pre-edge values; blocking here would collapse the synchronizer into one flop.
  always_ff @(posedge clk5) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync2;
          cnt   <= '0;
          // Only the accepted press edge pulses; an accepted release stays silent.
          pulse <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

module lap_recall #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 15000000,
  parameter int DEPTH           = 4
) (
  input  logic                     clk5,
  input  logic                     reset,
  input  logic                     lapPB,
  input  logic                     recallPB,
  input  logic                     run,
  input  logic [15:0]              timevalue,
  output logic [15:0]              dispValue,
  output logic [$clog2(DEPTH):0]   lapCount,
  output logic                     holding,
  output logic                     recalling
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] HOLD_MAX  = TW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] CNT_FULL  = LW'(DEPTH);

  typedef enum logic [1:0] {
    LIVE,
    HOLD,
    RECALL
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_idx_q, rd_idx_d;
  logic [LW-1:0]   shown_q, shown_d;
  logic [LW-1:0]   lap_cnt_d;
  logic [TW-1:0]   hold_q, hold_d;
  logic [15:0]     disp_d;
  logic [15:0]     laps [DEPTH];
  logic [PW-1:0]   newest;
  logic [PW-1:0]   older;
  logic            capture;
  logic            lap_p;
  logic            recall_p;

  lap_recall_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
    .clk5  (clk5),
    .reset (reset),
    .raw   (lapPB),
    .pulse (lap_p)
  );

  lap_recall_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_recall_db (
    .clk5  (clk5),
    .reset (reset),
    .raw   (recallPB),
    .pulse (recall_p)
  );

  assign newest = wr_ptr_q - 1'b1;
  assign older  = rd_idx_q - 1'b1;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_idx_d  = rd_idx_q;
    shown_d   = shown_q;
    lap_cnt_d = lapCount;
    hold_d    = hold_q;
    disp_d    = dispValue;
    capture   = 1'b0;

    case (state_q)
      LIVE, HOLD: begin
        if (state_q == LIVE) disp_d = timevalue;
        // A capture wins over a same-cycle recall press, which is dropped.
        if (lap_p && run) begin
          capture  = 1'b1;
          state_d  = HOLD;
          hold_d   = HOLD_MAX;
          disp_d   = timevalue;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (lapCount != CNT_FULL) lap_cnt_d = lapCount + 1'b1;
        end else if (recall_p && (lapCount != '0)) begin
          state_d  = RECALL;
          rd_idx_d = newest;
          shown_d  = LW'(1);
          disp_d   = laps[newest];
        end else if (state_q == HOLD) begin
          if (hold_q == '0) begin
            state_d = LIVE;
            disp_d  = timevalue;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
      end
      RECALL: begin
        disp_d = laps[rd_idx_q];
        if (recall_p) begin
          if (shown_q == lapCount) begin
            state_d = LIVE;
            disp_d  = timevalue;
          end else begin
            rd_idx_d = older;
            shown_d  = shown_q + 1'b1;
            disp_d   = laps[older];
          end
        end
      end
      default: state_d = LIVE;
    endcase
  end

  always_ff @(posedge clk5) begin
    if (reset) begin
      state_q   <= LIVE;
      wr_ptr_q  <= '0;
      rd_idx_q  <= '0;
      shown_q   <= '0;
      lapCount  <= '0;
      hold_q    <= '0;
      dispValue <= '0;
      holding   <= 1'b0;
      recalling <= 1'b0;
      // NOTE: the lap store is reset on purpose so a recall right after reset
      // can never expose laps from a previous session.
      for (int i = 0; i < DEPTH; i++) laps[i] <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_idx_q  <= rd_idx_d;
      shown_q   <= shown_d;
      lapCount  <= lap_cnt_d;
      hold_q    <= hold_d;
      dispValue <= disp_d;
      holding   <= (state_d == HOLD);
      recalling <= (state_d == RECALL);
      if (capture) laps[wr_ptr_q] <= timevalue;
    end
  end

endmodule

// File: tb/tb_lap_recall.sv
// Directed bench for lap_recall with short debounce/hold times and DEPTH=4.

module tb_lap_recall;

  logic        clk5;
  logic        reset;
  logic        lapPB;
  logic        recallPB;
  logic        run;
  logic [15:0] timevalue;
  logic [15:0] dispValue;
  logic [2:0]  lapCount;
  logic        holding;
  logic        recalling;

  int checks = 0;
  int errors = 0;

  lap_recall #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .DEPTH           (4)
  ) dut (
    .clk5      (clk5),
    .reset     (reset),
    .lapPB     (lapPB),
    .recallPB  (recallPB),
    .run       (run),
    .timevalue (timevalue),
    .dispValue (dispValue),
    .lapCount  (lapCount),
    .holding   (holding),
    .recalling (recalling)
  );

  initial clk5 = 1'b0;
  always #5 clk5 = ~clk5;

  task automatic tick(input int n);
    repeat (n) @(negedge clk5);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A press driven at a falling edge is accepted and acted on at the 7th rising edge.
  localparam int PRESS = 7;

  initial begin
    reset     = 1'b1;
    lapPB     = 1'b0;
    recallPB  = 1'b0;
    run       = 1'b0;
    timevalue = 16'h0000;
    tick(2);
    check("rst_disp", dispValue, 16'h0000);
    check("rst_cnt", 16'(lapCount), 16'd0);
    check("rst_hold", 16'(holding), 16'd0);
    check("rst_recall", 16'(recalling), 16'd0);
    reset = 1'b0;

    // Glitches shorter than the debounce window must not capture.
    run       = 1'b1;
    timevalue = 16'h0123;
    for (int g = 0; g < 2; g++) begin
      lapPB = 1'b1;
      tick(2);
      lapPB = 1'b0;
      tick(6);
    end
    check("glitch_cnt", 16'(lapCount), 16'd0);
    check("glitch_hold", 16'(holding), 16'd0);
    check("live_disp", dispValue, 16'h0123);

    // Stable press captures, then the hold lasts exactly 10 cycles.
    lapPB = 1'b1;
    tick(PRESS);
    check("cap_cnt", 16'(lapCount), 16'd1);
    check("cap_hold", 16'(holding), 16'd1);
    check("cap_disp", dispValue, 16'h0123);
    timevalue = 16'h0124;
    lapPB     = 1'b0;
    tick(9);
    check("hold_end_disp", dispValue, 16'h0123);
    check("hold_end_hold", 16'(holding), 16'd1);
    tick(1);
    check("hold_exit_hold", 16'(holding), 16'd0);
    check("hold_exit_disp", dispValue, 16'h0124);
    timevalue = 16'h0130;
    check("latency_before", dispValue, 16'h0124);
    tick(1);
    check("latency_after", dispValue, 16'h0130);

    // Five captures into four entries; the oldest one is overwritten.
    for (int k = 1; k <= 5; k++) begin
      timevalue = 16'(k);
      lapPB     = 1'b1;
      tick(PRESS);
      check("fill_disp", dispValue, 16'(k));
      check("fill_cnt", 16'(lapCount), (k + 1 > 4) ? 16'd4 : 16'(k + 1));
      check("fill_hold", 16'(holding), 16'd1);
      lapPB = 1'b0;
      tick(PRESS);
    end
    timevalue = 16'h0999;
    tick(4);
    check("fill_live", 16'(holding), 16'd0);

    // Recall steps newest to oldest, ignores lap presses, then returns to live.
    recallPB = 1'b1;
    tick(PRESS);
    check("rc1_disp", dispValue, 16'h0005);
    check("rc1_flag", 16'(recalling), 16'd1);
    recallPB = 1'b0;
    tick(PRESS);
    check("rc1_stable", dispValue, 16'h0005);
    recallPB = 1'b1;
    tick(PRESS);
    check("rc2_disp", dispValue, 16'h0004);
    recallPB = 1'b0;
    tick(PRESS);
    lapPB = 1'b1;
    tick(PRESS);
    check("rc_lap_cnt", 16'(lapCount), 16'd4);
    check("rc_lap_disp", dispValue, 16'h0004);
    check("rc_lap_flag", 16'(recalling), 16'd1);
    lapPB = 1'b0;
    tick(PRESS);
    recallPB = 1'b1;
    tick(PRESS);
    check("rc3_disp", dispValue, 16'h0003);
    recallPB = 1'b0;
    tick(PRESS);
    recallPB = 1'b1;
    tick(PRESS);
    check("rc4_disp", dispValue, 16'h0002);
    recallPB = 1'b0;
    tick(PRESS);
    recallPB = 1'b1;
    tick(PRESS);
    check("rc5_flag", 16'(recalling), 16'd0);
    check("rc5_disp", dispValue, 16'h0999);
    check("rc5_cnt", 16'(lapCount), 16'd4);
    recallPB = 1'b0;
    tick(PRESS);

    // Lap press while stopped is ignored.
    run       = 1'b0;
    timevalue = 16'h0777;
    lapPB     = 1'b1;
    tick(PRESS);
    check("stop_cnt", 16'(lapCount), 16'd4);
    check("stop_hold", 16'(holding), 16'd0);
    check("stop_disp", dispValue, 16'h0777);
    lapPB = 1'b0;
    tick(PRESS);

    // Lap and recall accepted together: lap wins.
    run       = 1'b1;
    timevalue = 16'h0555;
    lapPB     = 1'b1;
    recallPB  = 1'b1;
    tick(PRESS);
    check("both_hold", 16'(holding), 16'd1);
    check("both_recall", 16'(recalling), 16'd0);
    check("both_disp", dispValue, 16'h0555);
    lapPB    = 1'b0;
    recallPB = 1'b0;
    tick(PRESS + 4);
    check("both_live", 16'(holding), 16'd0);

    // Reset in the middle of a recall.
    recallPB = 1'b1;
    tick(PRESS);
    check("pre_rst_flag", 16'(recalling), 16'd1);
    check("pre_rst_disp", dispValue, 16'h0555);
    recallPB = 1'b0;
    reset    = 1'b1;
    tick(1);
    check("mid_rst_disp", dispValue, 16'h0000);
    check("mid_rst_cnt", 16'(lapCount), 16'd0);
    check("mid_rst_flag", 16'(recalling), 16'd0);
    check("mid_rst_hold", 16'(holding), 16'd0);
    reset = 1'b0;
    tick(PRESS);
    recallPB = 1'b1;
    tick(PRESS);
    check("empty_rc_flag", 16'(recalling), 16'd0);
    check("empty_rc_disp", dispValue, 16'h0555);
    recallPB = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
